// File: rtl/mem_port_arbiter_if.sv
// Bundle of the core-side fetch/data ports and the memory-side port of mem_port_arbiter.
// The slave modport is the arbiter's view; master is the view of whatever drives it.
interface mem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 14
);
  logic              i_req;
  logic [31:0]       i_addr;
  logic              i_ready;
  logic [31:0]       i_rdata;

  logic              d_req;
  logic              d_we;
  logic [2:0]        d_func3;
  logic [31:0]       d_addr;
  logic [31:0]       d_wdata;
  logic              d_ready;
  logic [31:0]       d_rdata;
  logic              d_err;

  logic              mem_en;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  modport slave (
    input  i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, d_err,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );

  modport master (
    output i_req, i_addr, d_req, d_we, d_func3, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, d_err,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port word memory between the fetch and data ports of an RV32I core,
// with fixed-latency access sequencing and byte-lane steering for loads and stores.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W    = 14,
  parameter int unsigned MEM_LAT   = 1,
  parameter bit          PRIO_DATA = 1'b1
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StAccess, StWait, StResp} state_e;

  state_e     state_q;
  logic [2:0] cnt_q;
  logic       last_grant_q;  // 1 = data port won the last grant
  logic       gnt_data_q;
  logic       we_q;
  logic [2:0] func3_q;
  logic [1:0] off_q;

  logic [1:0]  d_off;
  logic        req_err;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic        grant_d;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign d_off = bus.d_addr[1:0];

  // With round-robin, data wins a conflict unless it won the previous one.
  assign grant_d = bus.d_req & (~bus.i_req | PRIO_DATA | ~last_grant_q);

  always_comb begin
    req_err  = 1'b0;
    st_be    = 4'hF;
    st_wdata = bus.d_wdata;
    if (bus.d_we) begin
      case (bus.d_func3)
        3'd0: begin
          st_be    = 4'b0001 << d_off;
          st_wdata = {4{bus.d_wdata[7:0]}};
        end
        3'd1: begin
          st_be    = 4'b0011 << d_off;
          st_wdata = {2{bus.d_wdata[15:0]}};
          req_err  = d_off[0];
        end
        3'd2:    req_err = (d_off != 2'd0);
        default: req_err = 1'b1;
      endcase
    end else begin
      case (bus.d_func3)
        3'd0, 3'd4: req_err = 1'b0;
        3'd1, 3'd5: req_err = d_off[0];
        3'd2:       req_err = (d_off != 2'd0);
        default:    req_err = 1'b1;
      endcase
    end
  end

  assign ld_byte = bus.mem_rdata[{off_q, 3'b000} +: 8];
  assign ld_half = off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

  always_comb begin
    case (func3_q)
      3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'd4:    ld_data = {24'h0, ld_byte};
      3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
      3'd5:    ld_data = {16'h0, ld_half};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      last_grant_q  <= 1'b0;
      gnt_data_q    <= 1'b0;
      we_q          <= 1'b0;
      func3_q       <= '0;
      off_q         <= '0;
      bus.i_ready   <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_ready   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      // Outputs are single-cycle unless a state below re-asserts them.
      bus.i_ready   <= 1'b0;
      bus.i_rdata   <= '0;
      bus.d_ready   <= 1'b0;
      bus.d_rdata   <= '0;
      bus.d_err     <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      unique case (state_q)
        StIdle: begin
          if (bus.i_req || bus.d_req) begin
            gnt_data_q   <= grant_d;
            last_grant_q <= grant_d;
            if (grant_d) begin
              we_q    <= bus.d_we;
              func3_q <= bus.d_func3;
              off_q   <= d_off;
              if (req_err) begin
                bus.d_ready <= 1'b1;
                bus.d_err   <= 1'b1;
                state_q     <= StResp;
              end else begin
                bus.mem_en    <= 1'b1;
                bus.mem_we    <= bus.d_we;
                bus.mem_be    <= st_be;
                bus.mem_addr  <= bus.d_addr[ADDR_W+1:2];
                bus.mem_wdata <= bus.d_we ? st_wdata : 32'h0;
                state_q       <= StAccess;
              end
            end else begin
              bus.mem_en   <= 1'b1;
              bus.mem_be   <= 4'hF;
              bus.mem_addr <= bus.i_addr[ADDR_W+1:2];
              state_q      <= StAccess;
            end
          end
        end
        StAccess: begin
          cnt_q   <= 3'(MEM_LAT);
          state_q <= StWait;
        end
        StWait: begin
          if (cnt_q == 3'd1) begin
            state_q <= StResp;
            if (gnt_data_q) begin
              bus.d_ready <= 1'b1;
              bus.d_rdata <= we_q ? 32'h0 : ld_data;
            end else begin
              bus.i_ready <= 1'b1;
              bus.i_rdata <= bus.mem_rdata;
            end
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StResp:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  // Word offset and bits beyond the memory size take no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.i_addr[31:ADDR_W+2], bus.i_addr[1:0],
                              bus.d_addr[31:ADDR_W+2]};

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous word-wide memory between the core's instruction-fetch port and data port.
- Arbitrates between the two requesters and sequences each memory access through a fixed-latency FSM.
- Steers byte lanes for SB/SH/SW stores and LB/LH/LW/LBU/LHU loads.
- Returns the response with a one-cycle ready pulse; the core stalls until it arrives.

Parameters:
- ADDR_W, 14: word-address width of the memory (memory depth is 2^ADDR_W words).
- MEM_LAT, 1: memory read latency in cycles, range 1..4.
- PRIO_DATA, 1: 1 = the data port always wins; 0 = round-robin between the two ports.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- i_req  in  1  instruction fetch request; held until i_ready.
- i_addr  in  32  fetch byte address; word-aligned.
- i_ready  out  1  one-cycle pulse: fetch complete.
- i_rdata  out  32  fetched word; valid while i_ready=1.
- d_req  in  1  data request; held until d_ready.
- d_we  in  1  1 = store, 0 = load.
- d_func3  in  3  RV32I load/store funct3.
- d_addr  in  32  data byte address.
- d_wdata  in  32  store data, right-justified.
- d_ready  out  1  one-cycle pulse: data access complete.
- d_rdata  out  32  extended load data; valid while d_ready=1.
- d_err  out  1  qualifies d_ready: misaligned address or illegal funct3.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_be  out  4  byte enables; bit k = byte lane k (bits 8k+7:8k).
- mem_addr  out  ADDR_W  word address, from byte address bits [ADDR_W+1:2].
- mem_wdata  out  32  lane-steered write data.
- mem_rdata  in  32  read data; valid MEM_LAT cycles after the cycle in which mem_en=1.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE and all outputs go to 0.
  - The latency counter clears and last_grant is set to INSTR.
  - Any in-flight access is abandoned; no ready pulse is issued for it.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Samples i_req and d_req.
  - Only one request asserted: that port is granted.
  - Both asserted, PRIO_DATA=1: data port is granted.
  - Both asserted, PRIO_DATA=0: the port opposite last_grant is granted. Data wins the first conflict after reset.
  - On grant, the request fields are latched, last_grant is updated, and the FSM goes to ACCESS.
  - A data request with an error goes straight to RESP with d_err=1. No memory access is made and d_rdata=0.
- ACCESS (exactly 1 cycle):
  - mem_en=1; mem_we, mem_be, mem_addr and mem_wdata are driven from the latched fields.
  - Outputs are registered.
  - Next state is WAIT; the counter loads MEM_LAT.
- WAIT:
  - The counter decrements each cycle.
  - When the counter reaches 1, mem_rdata is captured and steered, and the FSM goes to RESP.
- RESP (1 cycle):
  - The granted port's ready is 1, with rdata and d_err registered.
  - Next state is always IDLE, so a requester dropping req is never re-sampled stale.
- Latency:
  - Request sampled in IDLE at cycle N; mem_en=1 in cycle N+1; ready in cycle N+2+MEM_LAT.
  - Accepted requests are spaced MEM_LAT+3 cycles apart.
  - Error responses have ready in cycle N+1.
- Stores: ready is issued with the same timing as loads. mem_rdata is ignored and d_rdata=0.
- Fetch:
  - mem_be=4'hF, mem_we=0.
  - i_addr[1:0] is ignored (treated as 0).
- Store lane steering (off = d_addr[1:0]):
  - SB: mem_be = 1<<off; mem_wdata = the byte d_wdata[7:0] replicated 4 times.
  - SH: mem_be = 3<<off; mem_wdata = the halfword d_wdata[15:0] replicated 2 times. Error if off[0]=1.
  - SW: mem_be=F; mem_wdata=d_wdata. Error if off≠0.
- Load reads: mem_we=0, mem_be=F. Lanes are selected on return.
  - LB and LBU select byte lane off; LB sign-extends, LBU zero-extends.
  - LH and LHU select the halfword at off[1]; LH sign-extends, LHU zero-extends.
  - LW returns the whole word.
  - Misalignment rules match SH/SW.
- Illegal funct3 → d_err:
  - Loads: 3, 6, 7.
  - Stores: 3..7.
- Protocol and state rules:
  - Whichever of i_ready/d_ready is not pulsing is 0; the two never assert in the same cycle.
  - A request deasserted before its ready is a protocol violation; the latched access completes regardless.
  - Address bits above ADDR_W+1 are ignored, so addresses wrap modulo the memory size.

Test Plan:
- Fetch only, MEM_LAT=1: i_req, i_addr=0x10, memory word 4 = 0xDEADBEEF → mem_en=1, mem_addr=4 in cycle N+1; i_ready=1, i_rdata=0xDEADBEEF in cycle N+3.
- Byte store/load: SB addr=0x103, wdata=0x000000A5 → mem_be=4'b1000, mem_wdata=0xA5A5A5A5. Then LB from 0x103 → d_rdata=0xFFFFFFA5; LBU from 0x103 → 0x000000A5.
- Conflict, PRIO_DATA=0: i_req and d_req held continuously → grants alternate D, I, D, I. Each ready is MEM_LAT+3 cycles after the previous one; i_ready and d_ready never coincide.
- Misaligned: SW at 0x102 → d_ready=1, d_err=1 at N+1, mem_en never asserts. LH at 0x101 → same response. LHU at 0x102 with word 0x8001xxxx → d_rdata=0x00008001, d_err=0.
- MEM_LAT=3, LW: mem_en in cycle N+1 → d_ready in cycle N+5 with the correct word.
- Reset mid-operation: reset=0 during WAIT → all outputs 0 immediately, no ready pulse. After release, a new fetch completes normally, and a simultaneous D/I conflict grants data first.
